ram_param: RTL and testbench

Parametrised single-port word RAM, successor to the fixed 16-bit/14-bit-address RAM used across the memory and program-counter work. Width and depth are generic, the read is combinational, and the write is synchronous. A built-in clear sequencer zeroes every word after reset or on request, and a `busy` flag blocks access while the sweep runs. It serves as the data/instruction store behind the CPU and PC blocks.

---
 rtl/ram_param.sv | 93 +++++++++
 tb/tb_ram_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_param.sv
// ram_param: generic single-port word RAM, combinational read, synchronous write.
// Optional zero-sweep sequencer with busy gating compiled in by RAM_PARAM_CLEAR_EN.
module ram_param #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

`ifdef RAM_PARAM_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Terminal compare on LAST keeps ptr from wrapping inside SWEEP
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (clear) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy  = (state_q == SWEEP);
    assign we    = busy | (load & ~clear);
    assign waddr = busy ? ptr_q : address;
    assign wdata = busy ? '0 : in;
    assign out   = busy ? '0 : mem_q[address];
`else
    logic unused_ctrl;

    assign unused_ctrl = reset ^ clear;
    assign busy        = 1'b0;
    assign we          = load;
    assign waddr       = address;
    assign wdata       = in;
    assign out         = mem_q[address];
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: directed and random checks of ram_param against a word-map model.
// Sweep model: a clear or reset zeroes everything and blocks access for DEPTH edges.
module tb_ram_param;
`ifdef RAM_PARAM_CLEAR_EN
    localparam int AW = 4;
`else
    localparam int AW = 14;
`endif
    localparam int W     = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          load    = 1'b0;
    logic          clear   = 1'b0;
    logic [AW-1:0] address = '0;
    logic [W-1:0]  din     = '0;
    logic [W-1:0]  dout;
    logic          busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [W-1:0] m [int];
    bit           zeroed  = 1'b0;
    int           blocked = 0;

    ram_param #(
        .WIDTH (W),
        .ADDR_W(AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .address(address),
        .in     (din),
        .load   (load),
        .clear  (clear),
        .out    (dout),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit known(logic [AW-1:0] a);
        return (blocked > 0) || zeroed || m.exists(int'(a));
    endfunction

    function automatic logic [W-1:0] expv(logic [AW-1:0] a);
        if (blocked > 0) return '0;
        if (m.exists(int'(a))) return m[int'(a)];
        return '0;
    endfunction

    task automatic start_sweep();
        blocked = DEPTH;
        m.delete();
        zeroed = 1'b1;
    endtask

    task automatic model_edge();
`ifdef RAM_PARAM_CLEAR_EN
        if (reset) start_sweep();
        else if (clear) start_sweep();
        else if (blocked > 0) blocked--;
        else if (load) m[int'(address)] = din;
`else
        if (load) m[int'(address)] = din;
`endif
    endtask

    task automatic check_out(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(blocked > 0));
        if (known(address)) chk({tag, "_out"}, 32'(dout), 32'(expv(address)));
    endtask

    task automatic cycle(logic [AW-1:0] a, logic [W-1:0] d,
                         logic ld, logic cl, string tag);
        address = a;
        din     = d;
        load    = ld;
        clear   = cl;
        @(posedge clk);
        model_edge();
        #1;
        check_out(tag);
    endtask

    task automatic peek(logic [AW-1:0] a, string tag);
        address = a;
        load    = 1'b0;
        clear   = 1'b0;
        #1;
        check_out(tag);
    endtask

    task automatic assert_reset(string tag);
        reset = 1'b1;
`ifdef RAM_PARAM_CLEAR_EN
        start_sweep();
`endif
        #1;
        check_out(tag);
    endtask

    task automatic drain(string tag, int want);
        int n;
        n = 0;
        while (busy && n < 4 * DEPTH) begin
            cycle(AW'($urandom), W'($urandom), 1'b1, 1'b0, tag);
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'(want));
    endtask

    initial begin
`ifdef RAM_PARAM_CLEAR_EN
        // Reset sweep
        #1;
        assert_reset("t1_rst");
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check_out("t1_hold");
        reset = 1'b0;
        drain("t1_sweep", DEPTH);
        peek(AW'(0), "t1_r0");
        peek(AW'(3), "t1_r3");
        peek(AW'(7), "t1_r7");
        peek(AW'(15), "t1_r15");

        // Write and readback
        cycle(AW'(0), 16'h1234, 1'b1, 1'b0, "t2_w0");
        cycle(AW'(3), 16'hBEEF, 1'b1, 1'b0, "t2_w3");
        cycle(AW'(7), 16'h00FF, 1'b1, 1'b0, "t2_w7");
        cycle(AW'(15), 16'hFFFF, 1'b1, 1'b0, "t2_w15");
        cycle(AW'(0), 16'h9999, 1'b0, 1'b0, "t2_k0");
        cycle(AW'(3), 16'h8888, 1'b0, 1'b0, "t2_k3");
        cycle(AW'(7), 16'h7777, 1'b0, 1'b0, "t2_k7");
        cycle(AW'(15), 16'h6666, 1'b0, 1'b0, "t2_k15");

        // Load gating during a sweep and on the clear edge
        cycle(AW'(5), 16'h1111, 1'b1, 1'b0, "t3_w5");
        cycle(AW'(2), 16'h2222, 1'b1, 1'b0, "t3_w2");
        cycle(AW'(5), 16'h0000, 1'b0, 1'b1, "t3_clr");
        while (busy && blocked > 0)
            cycle(AW'(5), 16'hAAAA, 1'b1, 1'b0, "t3_sw");
        peek(AW'(5), "t3_r5");
        cycle(AW'(2), 16'h3333, 1'b1, 1'b0, "t3_w2b");
        cycle(AW'(2), 16'h5555, 1'b1, 1'b1, "t3_clrld");
        drain("t3_sw2", DEPTH);
        peek(AW'(2), "t3_r2");

        // Clear restart mid-sweep
        cycle(AW'(9), 16'h4321, 1'b1, 1'b0, "t4_w9");
        cycle(AW'(0), 16'h0, 1'b0, 1'b1, "t4_clr1");
        repeat (8) cycle(AW'($urandom), W'($urandom), 1'b1, 1'b0, "t4_a");
        cycle(AW'(0), 16'h0, 1'b0, 1'b1, "t4_clr2");
        drain("t4_sw", DEPTH);
        for (int i = 0; i < DEPTH; i++)
            cycle(AW'(i), W'($urandom), 1'b0, 1'b0, "t4_zero");

        // Reset in the middle of a sweep
        cycle(AW'(4), 16'h7E57, 1'b1, 1'b0, "t5_w4");
        cycle(AW'(0), 16'h0, 1'b0, 1'b1, "t5_clr");
        repeat (9) cycle(AW'($urandom), W'($urandom), 1'b1, 1'b0, "t5_a");
        assert_reset("t5_rst");
        repeat (3) cycle(AW'($urandom), W'($urandom), 1'b1, 1'b0, "t5_hold");
        reset = 1'b0;
        drain("t5_sw", DEPTH);
        peek(AW'(4), "t5_r4");

        // Random traffic with occasional clears
        for (int i = 0; i < 500; i++)
            cycle(AW'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0), "rnd");
`else
        // No sequencer: reset and clear leave the store alone
        #1;
        assert_reset("u_rst");
        cycle(AW'(14'h3FFF), 16'hCAFE, 1'b1, 1'b0, "u_w");
        reset = 1'b0;
        cycle(AW'(14'h3FFF), 16'h0, 1'b0, 1'b1, "u_clr1");
        assert_reset("u_rst2");
        cycle(AW'(14'h3FFF), 16'h1, 1'b0, 1'b1, "u_clr2");
        reset = 1'b0;
        cycle(AW'(14'h3FFF), 16'h2, 1'b0, 1'b0, "u_keep");
        for (int i = 0; i < 500; i++) begin
            reset = 1'($urandom_range(0, 7) == 0);
            cycle(AW'($urandom_range(0, 63)), W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "u_rnd");
        end
        reset = 1'b0;
        peek(AW'(14'h3FFF), "u_final");
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
